// File: rtl/avg_frame_ctrl.sv
// avg_frame_ctrl: sequences one AVG vector frame from CPU start request
// through AVG run, line-queue drain, vsync wait and framebuffer swap.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no frame in progress; waits for cpu_vggo or a pending request
// START   | avg_vggo held high for GO_HOLD cycles; avg_halted ignored
// RUN     | AVG drawing; watchdog running; queue drained as lines appear
// DRAIN   | AVG halted (or timed out); empty the line queue
// WAIT_VS | queue empty; wait for a vsync rising edge
// SWAP    | one-cycle framebuffer swap, frame_count advances
module avg_frame_ctrl #(
  parameter int GO_HOLD     = 16,
  parameter int WDOG_CYCLES = 65535
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       cpu_vggo,
  input  logic       vsync,
  input  logic       avg_halted,
  output logic       avg_vggo,
  input  logic       q_empty,
  output logic       q_read,
  output logic       draw_valid,
  input  logic       draw_ready,
  output logic       buf_swap,
  output logic       busy,
  output logic       timeout_err,
  output logic [7:0] frame_count
);

  localparam int GO_W = (GO_HOLD > 1) ? $clog2(GO_HOLD) : 1;
  localparam int WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [GO_W-1:0] GO_LAST = GO_W'(GO_HOLD - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    RUN     = 3'd2,
    DRAIN   = 3'd3,
    WAIT_VS = 3'd4,
    SWAP    = 3'd5
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            pending;
  logic            pending_nxt;
  logic [GO_W-1:0] go_cnt;
  logic [WD_W-1:0] wdog;
  logic            vsync_q;
  logic            vsync_rise;
  logic            timeout_hit;

  // A vsync level already high when we arrive in WAIT_VS is not an edge,
  // because vsync_q has been tracking it all along.
  assign vsync_rise = vsync & ~vsync_q;

  // Next-state, request bookkeeping and the combinational drain handshake.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    timeout_hit = 1'b0;
    draw_valid  = 1'b0;
    q_read      = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_vggo || pending) begin
          state_nxt   = START;
          pending_nxt = 1'b0;
        end
      end
      START: begin
        if (go_cnt == '0) state_nxt = RUN;
      end
      RUN: begin
        draw_valid = !q_empty;
        q_read     = draw_valid && draw_ready;
        // A halt on the watchdog's last cycle is a normal finish, not a timeout.
        if (avg_halted) begin
          state_nxt = DRAIN;
        end else if (wdog == WD_LAST) begin
          state_nxt   = DRAIN;
          timeout_hit = 1'b1;
        end
      end
      DRAIN: begin
        draw_valid = !q_empty;
        q_read     = draw_valid && draw_ready;
        if (q_empty) state_nxt = WAIT_VS;
      end
      WAIT_VS: begin
        if (vsync_rise) state_nxt = SWAP;
      end
      SWAP: begin
        if (pending) begin
          state_nxt   = START;
          pending_nxt = 1'b0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Outside IDLE a request is parked in a single bit; extras collapse into it.
    if (cpu_vggo && (state != IDLE)) pending_nxt = 1'b1;
  end

  // State, timers, vsync history and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= 1'b0;
      go_cnt      <= GO_LAST;
      wdog        <= '0;
      vsync_q     <= 1'b0;
      timeout_err <= 1'b0;
      frame_count <= 8'd0;
      avg_vggo    <= 1'b0;
      buf_swap    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      pending     <= pending_nxt;
      go_cnt      <= (state == START) ? go_cnt - GO_W'(1) : GO_LAST;
      wdog        <= (state == RUN) ? wdog + WD_W'(1) : '0;
      vsync_q     <= vsync;
      if (timeout_hit) timeout_err <= 1'b1;
      if (state_nxt == SWAP) frame_count <= frame_count + 8'd1;
      avg_vggo    <= (state_nxt == START);
      buf_swap    <= (state_nxt == SWAP);
      busy        <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_avg_frame_ctrl.sv
// Directed bench for avg_frame_ctrl (GO_HOLD=16, WDOG_CYCLES=100).
module tb_avg_frame_ctrl;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_vggo = 1'b0;
  logic       vsync = 1'b0;
  logic       avg_halted = 1'b0;
  logic       q_empty = 1'b1;
  logic       draw_ready = 1'b0;
  logic       avg_vggo;
  logic       q_read;
  logic       draw_valid;
  logic       buf_swap;
  logic       busy;
  logic       timeout_err;
  logic [7:0] frame_count;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_fc  = 0;

  always #5 clk_in = ~clk_in;

  avg_frame_ctrl #(.GO_HOLD(16), .WDOG_CYCLES(100)) dut (
    .clk_in(clk_in), .rst(rst), .cpu_vggo(cpu_vggo), .vsync(vsync),
    .avg_halted(avg_halted), .avg_vggo(avg_vggo), .q_empty(q_empty),
    .q_read(q_read), .draw_valid(draw_valid), .draw_ready(draw_ready),
    .buf_swap(buf_swap), .busy(busy), .timeout_err(timeout_err),
    .frame_count(frame_count)
  );

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic pulse_go();
    cpu_vggo = 1'b1;
    cyc();
    cpu_vggo = 1'b0;
  endtask

  // Counts avg_vggo-high cycles; returns at the first RUN cycle.
  task automatic wait_start(output int hi);
    hi = 0;
    while (avg_vggo === 1'b1 && hi < 64) begin
      hi++;
      cyc();
    end
  endtask

  // From a RUN cycle with an empty queue: halt, drain, vsync edge; returns in SWAP.
  task automatic end_frame();
    avg_halted = 1'b1;
    q_empty    = 1'b1;
    vsync      = 1'b0;
    cyc();
    cyc();
    vsync = 1'b1;
    cyc();
    vsync      = 1'b0;
    avg_halted = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; q_empty = 1'b0; draw_ready = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    n_tests++;
    if ({avg_vggo, buf_swap, busy, timeout_err, q_read, draw_valid} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 000000",
               {avg_vggo, buf_swap, busy, timeout_err, q_read, draw_valid});
    end
    n_tests++;
    if (frame_count !== 8'd0) begin
      n_fail++; $display("FAIL reset_frame_count: got %0d want 0", frame_count);
    end
    q_empty = 1'b1; draw_ready = 1'b0;
    cyc();
  endtask

  task automatic test_start_hold();
    int hi;
    int swaps;
    int lost;
    avg_halted = 1'b1; q_empty = 1'b1; vsync = 1'b0;
    pulse_go();
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL start_busy: got %b want 1", busy); end
    wait_start(hi);
    n_tests++;
    if (hi != 16) begin n_fail++; $display("FAIL start_hold_len: got %0d want 16", hi); end
    avg_halted = 1'b0;
    swaps = 0; lost = 0;
    for (int i = 0; i < 40; i++) begin
      vsync = ((i % 10) >= 5);
      cyc();
      if (buf_swap !== 1'b0) swaps++;
      if (busy !== 1'b1) lost++;
    end
    n_tests++;
    if (swaps != 0 || lost != 0) begin
      n_fail++; $display("FAIL run_held: got swaps=%0d idle=%0d want 0 0", swaps, lost);
    end
    q_empty = 1'b0; draw_ready = 1'b0; vsync = 1'b0;
    #1;
    n_tests++;
    if (draw_valid !== 1'b1 || q_read !== 1'b0) begin
      n_fail++; $display("FAIL run_offer: got valid=%b read=%b want 1 0", draw_valid, q_read);
    end
    end_frame();
    exp_fc = 1;
    n_tests++;
    if (buf_swap !== 1'b1 || frame_count !== exp_fc[7:0]) begin
      n_fail++; $display("FAIL start_swap: got swap=%b fc=%0d want 1 %0d", buf_swap, frame_count, exp_fc);
    end
    cyc();
    n_tests++;
    if (buf_swap !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL start_back_idle: got swap=%b busy=%b want 0 0", buf_swap, busy);
    end
  endtask

  task automatic test_drain();
    int hi;
    int q_cnt;
    int pops;
    int bad;
    int swaps;
    logic popped;
    logic exp_rd;
    logic [3:0] pat;
    pat = 4'b1101;
    avg_halted = 1'b0; q_empty = 1'b1; vsync = 1'b0;
    pulse_go();
    wait_start(hi);
    avg_halted = 1'b1;
    q_cnt = 3; pops = 0; bad = 0;
    for (int i = 0; i < 4; i++) begin
      draw_ready = pat[i];
      q_empty    = (q_cnt == 0);
      #1;
      exp_rd = (q_cnt != 0) && pat[i];
      if (draw_valid !== (q_cnt != 0) || q_read !== exp_rd) bad++;
      popped = (q_read === 1'b1);
      if (popped) pops++;
      cyc();
      if (popped && q_cnt > 0) q_cnt--;
    end
    n_tests++;
    if (pops != 3 || bad != 0) begin
      n_fail++; $display("FAIL drain_reads: got pops=%0d bad=%0d want 3 0", pops, bad);
    end
    q_empty = 1'b1; draw_ready = 1'b1; vsync = 1'b1;
    #1;
    n_tests++;
    if (draw_valid !== 1'b0 || q_read !== 1'b0) begin
      n_fail++; $display("FAIL drain_empty: got valid=%b read=%b want 0 0", draw_valid, q_read);
    end
    cyc();
    q_empty = 1'b0;
    #1;
    n_tests++;
    if (draw_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL wait_vs_entered: got valid=%b busy=%b want 0 1", draw_valid, busy);
    end
    q_empty = 1'b1; draw_ready = 1'b0;
    swaps = 0;
    repeat (3) begin cyc(); if (buf_swap !== 1'b0) swaps++; end
    n_tests++;
    if (swaps != 0) begin n_fail++; $display("FAIL vsync_prehigh: got swaps=%0d want 0", swaps); end
    vsync = 1'b0; cyc();
    vsync = 1'b1; cyc();
    exp_fc = 2;
    n_tests++;
    if (buf_swap !== 1'b1 || frame_count !== exp_fc[7:0]) begin
      n_fail++; $display("FAIL drain_swap: got swap=%b fc=%0d want 1 %0d", buf_swap, frame_count, exp_fc);
    end
    vsync = 1'b0; cyc();
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL drain_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_timeout();
    int hi;
    int n;
    int swaps;
    avg_halted = 1'b0; q_empty = 1'b1; vsync = 1'b0;
    pulse_go();
    wait_start(hi);
    n = 0;
    while (timeout_err !== 1'b1 && n < 300) begin cyc(); n++; end
    n_tests++;
    if (n != 100) begin n_fail++; $display("FAIL timeout_cycle: got %0d want 100", n); end
    q_empty = 1'b0;
    #1;
    n_tests++;
    if (draw_valid !== 1'b1) begin n_fail++; $display("FAIL timeout_drain: got valid=%b want 1", draw_valid); end
    q_empty = 1'b1;
    cyc();
    vsync = 1'b1; swaps = 0;
    repeat (6) begin cyc(); if (buf_swap === 1'b1) swaps++; end
    vsync = 1'b0;
    exp_fc = 3;
    n_tests++;
    if (swaps != 1 || frame_count !== exp_fc[7:0]) begin
      n_fail++; $display("FAIL timeout_swap: got swaps=%0d fc=%0d want 1 %0d", swaps, frame_count, exp_fc);
    end
    n_tests++;
    if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL timeout_sticky: got err=%b busy=%b want 1 0", timeout_err, busy);
    end
  endtask

  task automatic test_reset_mid();
    int hi;
    avg_halted = 1'b0; q_empty = 1'b1;
    pulse_go();
    wait_start(hi);
    avg_halted = 1'b1; q_empty = 1'b0; draw_ready = 1'b1;
    cyc();
    n_tests++;
    if (q_read !== 1'b1) begin n_fail++; $display("FAIL mid_pre_drain: got read=%b want 1", q_read); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    exp_fc = 0;
    n_tests++;
    if ({busy, q_read, draw_valid, avg_vggo, buf_swap} !== 5'b0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %b want 00000", {busy, q_read, draw_valid, avg_vggo, buf_swap});
    end
    n_tests++;
    if (frame_count !== exp_fc[7:0] || timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_regs: got fc=%0d err=%b want 0 0", frame_count, timeout_err);
    end
    avg_halted = 1'b0; q_empty = 1'b1; draw_ready = 1'b0;
    cyc();
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_stays_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_halt_at_limit();
    int hi;
    avg_halted = 1'b0; q_empty = 1'b1; vsync = 1'b0;
    pulse_go();
    wait_start(hi);
    repeat (99) cyc();
    avg_halted = 1'b1;
    cyc();
    q_empty = 1'b0;
    #1;
    n_tests++;
    if (timeout_err !== 1'b0 || draw_valid !== 1'b1) begin
      n_fail++; $display("FAIL halt_wins: got err=%b valid=%b want 0 1", timeout_err, draw_valid);
    end
    q_empty = 1'b1;
    cyc();
    vsync = 1'b1; cyc();
    vsync = 1'b0; avg_halted = 1'b0; cyc();
    exp_fc = 1;
    n_tests++;
    if (frame_count !== exp_fc[7:0] || timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL halt_limit_end: got fc=%0d err=%b want %0d 0", frame_count, timeout_err, exp_fc);
    end
  endtask

  task automatic test_back_to_back();
    int hi;
    rst = 1'b1; cyc(); rst = 1'b0;
    exp_fc = 0;
    avg_halted = 1'b0; q_empty = 1'b1; vsync = 1'b0;
    pulse_go();
    wait_start(hi);
    repeat (2) cyc();
    cpu_vggo = 1'b1; cyc(); cpu_vggo = 1'b0;
    repeat (2) cyc();
    cpu_vggo = 1'b1; cyc(); cpu_vggo = 1'b0;
    end_frame();
    cyc();
    n_tests++;
    if (avg_vggo !== 1'b1) begin n_fail++; $display("FAIL b2b_restart: got avg_vggo=%b want 1", avg_vggo); end
    wait_start(hi);
    n_tests++;
    if (hi != 16) begin n_fail++; $display("FAIL b2b_hold_len: got %0d want 16", hi); end
    end_frame();
    cyc();
    repeat (4) cyc();
    exp_fc = 2;
    n_tests++;
    if (busy !== 1'b0 || avg_vggo !== 1'b0 || frame_count !== exp_fc[7:0]) begin
      n_fail++; $display("FAIL b2b_single_extra: got busy=%b go=%b fc=%0d want 0 0 %0d",
                         busy, avg_vggo, frame_count, exp_fc);
    end
  endtask

  task automatic test_swap_request();
    int hi;
    int n;
    pulse_go();
    wait_start(hi);
    end_frame();
    cpu_vggo = 1'b1; cyc(); cpu_vggo = 1'b0;
    n = 0;
    while (avg_vggo !== 1'b1 && n < 10) begin cyc(); n++; end
    n_tests++;
    if (n != 1) begin n_fail++; $display("FAIL swap_request: got %0d cycles want 1", n); end
    wait_start(hi);
    end_frame();
    cyc();
    exp_fc = 4;
    n_tests++;
    if (frame_count !== exp_fc[7:0] || busy !== 1'b0) begin
      n_fail++; $display("FAIL swap_request_end: got fc=%0d busy=%b want %0d 0", frame_count, busy, exp_fc);
    end
  endtask

  task automatic test_wrap();
    int hi;
    rst = 1'b1; cyc(); rst = 1'b0;
    avg_halted = 1'b0; q_empty = 1'b1; vsync = 1'b0;
    for (int k = 0; k < 255; k++) begin
      pulse_go(); wait_start(hi); end_frame(); cyc();
    end
    exp_fc = 255;
    n_tests++;
    if (frame_count !== exp_fc[7:0]) begin n_fail++; $display("FAIL wrap_pre: got %0d want 255", frame_count); end
    pulse_go(); wait_start(hi); end_frame();
    exp_fc = 0;
    n_tests++;
    if (frame_count !== exp_fc[7:0] || buf_swap !== 1'b1) begin
      n_fail++; $display("FAIL wrap_zero: got fc=%0d swap=%b want 0 1", frame_count, buf_swap);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_start_hold();
    test_drain();
    test_timeout();
    test_reset_mid();
    test_halt_at_limit();
    test_back_to_back();
    test_swap_request();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule
